cache_axi_dm: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache with an AXI4 master port.

---
 rtl/cache_axi_dm_pkg.sv | 19 +
 rtl/cache_axi_dm_tags.sv | 35 +++
 rtl/cache_axi_dm.sv | 191 +++++++++++++++++++
 tb/tb_cache_axi_dm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_dm_pkg.sv
// cache_axi_dm_pkg: shared state encoding, AXI constants and helpers for the direct-mapped cache
package cache_axi_dm_pkg;
    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESP, WB_ADDR, WB_DATA, WB_RESP, RF_ADDR, RF_DATA
    } state_t;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic logic [31:0] merge_bytes(input logic [31:0] od, input logic [31:0] nd,
                                                input logic [3:0] strb);
        for (int i = 0; i < 4; i++) od[i*8 +: 8] = strb[i] ? nd[i*8 +: 8] : od[i*8 +: 8];
        return od;
    endfunction
endpackage

// File: rtl/cache_axi_dm_tags.sv
// cache_axi_dm_tags: per-line valid/dirty/tag flops, one read index, one write port, cleared by RST
module cache_axi_dm_tags import cache_axi_dm_pkg::*; #(
    parameter int LINES = 16,
    parameter int TW    = 23,
    localparam int IW   = clog2(LINES)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic          rd_dirty,
    output logic [TW-1:0] rd_tag,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_dirty,
    input  logic [TW-1:0] wr_tag
);
    logic [LINES-1:0] valid, dirty;
    logic [TW-1:0]    tag [LINES];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tag[rd_idx];
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= '0;
            dirty <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= wr_dirty;
        end
    end
    always_ff @(posedge CLK) begin
        if (we) tag[wr_idx] <= wr_tag;
    end
endmodule

// File: rtl/cache_axi_dm.sv
// cache_axi_dm: direct-mapped write-back/write-allocate data cache with AXI4 master port.
// Define CACHE_AXI_DM_STATS_EN to add saturating STAT_HIT/STAT_MISS/STAT_WB counters.
module cache_axi_dm import cache_axi_dm_pkg::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [31:0]           REQ_WDATA,
    input  logic [3:0]            REQ_WSTRB,
    output logic                  RESP_VALID,
    output logic [31:0]           RESP_RDATA,
    output logic                  RESP_ERR,
    output logic                  M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic                  M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic                  M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic                  M_AXI_RID,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
`ifdef CACHE_AXI_DM_STATS_EN
    ,
    output logic [31:0]           STAT_HIT,
    output logic [31:0]           STAT_MISS,
    output logic [31:0]           STAT_WB
`endif
);
    localparam int OW = clog2(LINE_WORDS);
    localparam int IW = clog2(LINES);
    localparam int TW = ADDR_WIDTH - IW - OW - 2;

    state_t          state, nxt;
    logic            req_we;
    logic [TW-1:0]   req_tag, t_tag, tag_wt;
    logic [IW-1:0]   req_idx;
    logic [OW-1:0]   req_off, beat, b_rd_off;
    logic [31:0]     req_wdata, ram_a_q, ram_b_q;
    logic [3:0]      req_wstrb;
    logic            t_valid, t_dirty, hit, last, tag_we, tag_wd, a_we, b_we, accept;
    logic [IW+OW-1:0] a_addr;
    logic [31:0]     mem [LINES*LINE_WORDS];
    logic            unused_ok;

    assign unused_ok = ^{M_AXI_BID, M_AXI_RID, REQ_ADDR[1:0]};
    assign accept    = REQ_READY && REQ_VALID;
    assign hit       = t_valid && t_tag == req_tag;
    assign last      = &beat;
    assign a_we      = state == LOOKUP && hit && req_we;
    assign b_we      = state == RF_DATA && M_AXI_RVALID;
    assign a_addr    = REQ_READY ? REQ_ADDR[IW+OW+1:2] : {req_idx, req_off};
    // Port B runs one word ahead so WDATA is already registered when the beat is offered.
    assign b_rd_off  = (state == WB_DATA && M_AXI_WREADY) ? beat + 1'b1 : beat;

    assign REQ_READY     = state == IDLE;
    assign RESP_VALID    = state == RESP;
    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWADDR  = {t_tag, req_idx, {(OW+2){1'b0}}};
    assign M_AXI_AWLEN   = 8'(LINE_WORDS - 1);
    assign M_AXI_AWSIZE  = SIZE_4B;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = state == WB_ADDR;
    assign M_AXI_WDATA   = ram_b_q;
    assign M_AXI_WSTRB   = 4'hf;
    assign M_AXI_WVALID  = state == WB_DATA;
    assign M_AXI_WLAST   = M_AXI_WVALID && last;
    assign M_AXI_BREADY  = state == WB_RESP;
    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARADDR  = {req_tag, req_idx, {(OW+2){1'b0}}};
    assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
    assign M_AXI_ARSIZE  = SIZE_4B;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARVALID = state == RF_ADDR;
    assign M_AXI_RREADY  = state == RF_DATA;

    cache_axi_dm_tags #(.LINES(LINES), .TW(TW)) u_tags (
        .CLK(CLK), .RST(RST), .rd_idx(req_idx), .rd_valid(t_valid), .rd_dirty(t_dirty),
        .rd_tag(t_tag), .we(tag_we), .wr_idx(req_idx), .wr_dirty(tag_wd), .wr_tag(tag_wt)
    );

    always_ff @(posedge CLK) begin
        state <= RST ? IDLE : nxt;
    end

    always_comb begin
        nxt    = state;
        tag_we = 1'b0;
        tag_wd = 1'b0;
        tag_wt = req_tag;
        case (state)
            IDLE:    nxt = REQ_VALID ? LOOKUP : IDLE;
            LOOKUP: begin
                nxt    = hit ? RESP : (t_valid && t_dirty) ? WB_ADDR : RF_ADDR;
                tag_we = a_we;
                tag_wd = 1'b1;
            end
            RESP:    nxt = IDLE;
            WB_ADDR: nxt = M_AXI_AWREADY ? WB_DATA : WB_ADDR;
            WB_DATA: nxt = (M_AXI_WREADY && last) ? WB_RESP : WB_DATA;
            WB_RESP: begin
                nxt    = M_AXI_BVALID ? RF_ADDR : WB_RESP;
                tag_we = M_AXI_BVALID;
                tag_wt = t_tag;
            end
            RF_ADDR: nxt = M_AXI_ARREADY ? RF_DATA : RF_ADDR;
            RF_DATA: begin
                nxt    = (M_AXI_RVALID && M_AXI_RLAST) ? LOOKUP : RF_DATA;
                tag_we = M_AXI_RVALID && M_AXI_RLAST;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RESP_RDATA <= '0;
            RESP_ERR   <= 1'b0;
            beat       <= '0;
        end else begin
            if (accept) begin
                req_we    <= REQ_WE;
                req_tag   <= REQ_ADDR[ADDR_WIDTH-1:IW+OW+2];
                req_idx   <= REQ_ADDR[IW+OW+1:OW+2];
                req_off   <= REQ_ADDR[OW+1:2];
                req_wdata <= REQ_WDATA;
                req_wstrb <= REQ_WSTRB;
                RESP_ERR  <= 1'b0;
            end
            if (state == LOOKUP) beat <= '0;
            if (state == LOOKUP && hit && !req_we) RESP_RDATA <= ram_a_q;
            if (state == WB_DATA && M_AXI_WREADY) beat <= beat + 1'b1;
            if (state == WB_RESP && M_AXI_BVALID && M_AXI_BRESP != RESP_OKAY) RESP_ERR <= 1'b1;
            if (b_we) begin
                beat <= beat + 1'b1;
                if (M_AXI_RRESP != RESP_OKAY || M_AXI_RLAST != last) RESP_ERR <= 1'b1;
            end
        end
    end

    // The final refill beat is forwarded so the retried lookup sees the freshly written word.
    always_ff @(posedge CLK) begin
        ram_a_q <= (b_we && {req_idx, beat} == a_addr) ? M_AXI_RDATA : mem[a_addr];
        ram_b_q <= mem[{req_idx, b_rd_off}];
        if (a_we) mem[a_addr] <= merge_bytes(ram_a_q, req_wdata, req_wstrb);
        if (b_we) mem[{req_idx, beat}] <= M_AXI_RDATA;
    end

`ifdef CACHE_AXI_DM_STATS_EN
    logic first;
    always_ff @(posedge CLK) begin
        if (RST) begin
            first     <= 1'b0;
            STAT_HIT  <= '0;
            STAT_MISS <= '0;
            STAT_WB   <= '0;
        end else begin
            if (accept) first <= 1'b1;
            if (state == LOOKUP) first <= 1'b0;
            if (state == LOOKUP && first && hit) STAT_HIT <= STAT_HIT + 32'(STAT_HIT != '1);
            if (state == LOOKUP && first && !hit) STAT_MISS <= STAT_MISS + 32'(STAT_MISS != '1);
            if (state == LOOKUP && !hit && t_valid && t_dirty) STAT_WB <= STAT_WB + 32'(STAT_WB != '1);
        end
    end
`endif
endmodule

// File: tb/tb_cache_axi_dm.sv
// tb_cache_axi_dm: directed and random requests against a flat-memory reference and an AXI slave model
module tb_cache_axi_dm;
    localparam int LINES = 16;
    localparam int LW    = 8;

    logic        clk = 1'b0;
    logic        RST;
    logic        REQ_VALID, REQ_READY, REQ_WE, RESP_VALID, RESP_ERR;
    logic [31:0] REQ_ADDR, REQ_WDATA, RESP_RDATA;
    logic [3:0]  REQ_WSTRB;
    logic        AWID, AWVALID, AWREADY, WLAST, WVALID, WREADY, BID, BVALID, BREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        ARID, ARVALID, ARREADY, RID, RLAST, RVALID, RREADY;

    int vectors = 0, fails = 0;
    logic [31:0] sl_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    logic [22:0] res_tag [LINES];
    bit          res_v [LINES];
    bit          res_d [LINES];
    int          ar_cnt = 0, aw_cnt = 0, max_stall = 0, rerr_beat = -1;
    logic [31:0] last_ar, last_aw;
    longint      ar_t, aw_t;
    bit          slave_busy = 0;

    always #5 clk = ~clk;

    cache_axi_dm dut (
        .CLK(clk), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .RESP_VALID(RESP_VALID),
        .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
        .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
        .M_AXI_AWBURST(AWBURST), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID),
        .M_AXI_WREADY(WREADY), .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
        .M_AXI_BREADY(BREADY), .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN),
        .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY), .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
        .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h5a5a_0000;
    endfunction
    function automatic logic [31:0] sl_rd(input logic [31:0] a);
        int unsigned k = int'(a >> 2);
        return sl_mem.exists(k) ? sl_mem[k] : init_word({a[31:2], 2'b00});
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int unsigned k = int'(a >> 2);
        return ref_mem.exists(k) ? ref_mem[k] : init_word({a[31:2], 2'b00});
    endfunction
    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic slave_read();
        logic [31:0] a;
        slave_busy = 1;
        idle_cycles($urandom_range(0, max_stall));
        ARREADY = 1;
        a = ARADDR;
        chk("arlen", ARLEN, LW - 1);
        @(posedge clk); #1;
        ARREADY = 0;
        ar_cnt++;
        last_ar = a;
        ar_t = $time;
        for (int b = 0; b < LW; b++) begin
            idle_cycles($urandom_range(0, max_stall));
            RVALID = 1;
            RDATA = sl_rd(a + 32'(b * 4));
            RLAST = (b == LW - 1);
            RRESP = (b == rerr_beat) ? 2'b10 : 2'b00;
            @(posedge clk); #1;
            RVALID = 0; RLAST = 0; RRESP = 0;
        end
        rerr_beat = -1;
        slave_busy = 0;
    endtask

    task automatic slave_write();
        logic [31:0] a, wd;
        slave_busy = 1;
        idle_cycles($urandom_range(0, max_stall));
        AWREADY = 1;
        a = AWADDR;
        chk("w_before_aw", WVALID, 0);
        @(posedge clk); #1;
        AWREADY = 0;
        aw_cnt++;
        last_aw = a;
        aw_t = $time;
        for (int b = 0; b < LW; b++) begin
            chk("wvalid", WVALID, 1);
            wd = WDATA;
            chk("wb_data", wd, ref_rd(a + 32'(b * 4)));
            repeat ($urandom_range(0, max_stall)) begin
                @(posedge clk); #1;
                chk("wdata_stable", WDATA, wd);
            end
            WREADY = 1;
            chk("wlast", WLAST, 32'(b == LW - 1));
            sl_mem[int'(a >> 2) + b] = WDATA;
            @(posedge clk); #1;
            WREADY = 0;
        end
        idle_cycles($urandom_range(0, max_stall));
        BVALID = 1;
        @(posedge clk); #1;
        BVALID = 0;
        slave_busy = 0;
    endtask

    initial begin : slave
        ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 0; RID = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
        forever begin
            @(posedge clk); #1;
            if (ARVALID && !RST) slave_read();
            else if (AWVALID && !RST) slave_write();
        end
    end

    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit exp_err, output logic [31:0] rd);
        int c, ar0, aw0, ix;
        bit exp_hit, exp_wb;
        logic [31:0] exp_rd, wb_addr;
        ix = int'(a[8:5]);
        ar0 = ar_cnt;
        aw0 = aw_cnt;
        exp_hit = res_v[ix] && res_tag[ix] == a[31:9];
        exp_wb = !exp_hit && res_v[ix] && res_d[ix];
        wb_addr = {res_tag[ix], a[8:5], 5'b0};
        exp_rd = ref_rd(a);
        chk("req_ready", REQ_READY, 1);
        REQ_VALID = 1; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = wd; REQ_WSTRB = ws;
        @(posedge clk); #1;
        REQ_VALID = 0; REQ_WE = 0;
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!RESP_VALID && c < 3000);
        chk("resp_timeout", RESP_VALID, 1);
        if (exp_hit) chk("hit_latency", c, 1);
        if (!we) chk("rdata", RESP_RDATA, exp_rd);
        rd = RESP_RDATA;
        chk("resp_err", RESP_ERR, exp_err);
        chk("ar_count", ar_cnt - ar0, exp_hit ? 0 : 1);
        chk("aw_count", aw_cnt - aw0, exp_wb ? 1 : 0);
        if (!exp_hit) chk("ar_addr", last_ar, {a[31:5], 5'b0});
        if (exp_wb) begin
            chk("aw_addr", last_aw, wb_addr);
            chk("aw_before_ar", 32'(aw_t < ar_t), 1);
        end
        @(posedge clk); #1;
        chk("resp_pulse", RESP_VALID, 0);
        if (!exp_hit) begin
            res_v[ix] = 1; res_tag[ix] = a[31:9]; res_d[ix] = 0;
        end
        if (we) begin
            res_d[ix] = 1;
            ref_mem[int'(a >> 2)] = mrg(exp_rd, wd, ws);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd, a;
        int c;
        for (int i = 0; i < LINES; i++) begin res_v[i] = 0; res_d[i] = 0; res_tag[i] = 0; end
        for (int b = 0; b < LW; b++) begin
            sl_mem[(32'h1000 >> 2) + b] = 32'(b);
            ref_mem[(32'h1000 >> 2) + b] = 32'(b);
        end
        RST = 1; REQ_VALID = 0; REQ_WE = 0; REQ_ADDR = 0; REQ_WDATA = 0; REQ_WSTRB = 0;
        idle_cycles(3);
        chk("rst_req_ready", REQ_READY, 1);
        chk("rst_resp_valid", RESP_VALID, 0);
        chk("rst_resp_err", RESP_ERR, 0);
        chk("rst_resp_rdata", RESP_RDATA, 0);
        chk("rst_axi_valids", {AWVALID, WVALID, WLAST, ARVALID, BREADY, RREADY}, 0);
        RST = 0;
        idle_cycles(1);
        do_req(0, 32'h1004, 0, 0, 0, rd);
        chk("t1_cold_read", rd, 1);
        do_req(0, 32'h1008, 0, 0, 0, rd);
        chk("t2_hit_read", rd, 2);
        do_req(1, 32'h1000, 32'h1122_3344, 4'hf, 0, rd);
        do_req(1, 32'h1000, 32'haabb_ccdd, 4'b0101, 0, rd);
        do_req(0, 32'h1000, 0, 0, 0, rd);
        chk("t3_merge", rd, 32'h11bb_33dd);
        do_req(0, 32'h1000 + LINES * 32, 0, 0, 0, rd);
        chk("t4_aw_addr", last_aw, 32'h1000);
        do_req(0, 32'h1000, 0, 0, 0, rd);
        chk("t4_wb_intact", rd, 32'h11bb_33dd);
        rerr_beat = 3;
        do_req(0, 32'h3004, 0, 0, 1, rd);
        do_req(0, 32'h3008, 0, 0, 0, rd);
        max_stall = 5;
        for (int i = 0; i < 150; i++) begin
            a = 32'h0001_0000 + ($urandom_range(0, 511) << 2);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)), 0, rd);
        end
        REQ_VALID = 1; REQ_WE = 0; REQ_ADDR = 32'h5000;
        @(posedge clk); #1;
        REQ_VALID = 0;
        c = 0;
        while (!RREADY && c < 500) begin @(posedge clk); #1; c++; end
        chk("t6_reach_refill", RREADY, 1);
        idle_cycles(2);
        RST = 1;
        @(posedge clk); #1;
        RST = 0;
        chk("t6_rst_ready", REQ_READY, 1);
        chk("t6_rst_rready", RREADY, 0);
        chk("t6_rst_err", RESP_ERR, 0);
        c = 0;
        while (slave_busy && c < 500) begin @(posedge clk); #1; c++; end
        chk("t6_slave_idle", slave_busy, 0);
        for (int i = 0; i < LINES; i++) begin res_v[i] = 0; res_d[i] = 0; end
        ref_mem.delete();
        foreach (sl_mem[k]) ref_mem[k] = sl_mem[k];
        c = ar_cnt;
        do_req(0, 32'h1008, 0, 0, 0, rd);
        chk("t6_refetch_after_rst", ar_cnt - c, 1);
        for (int i = 0; i < 20; i++) begin
            a = 32'h0001_0000 + ($urandom_range(0, 511) << 2);
            do_req(0, a, 0, 0, 0, rd);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
